uart_regs_fifo: RTL and testbench

Memory-mapped register block for the next-generation UART. It replaces single-entry TX/RX data registers with parametrised TX and RX FIFOs, and adds a programmable baud divisor, sticky error flags, FIFO level reporting and a level-sensitive interrupt. It sits between the APB slave decode (addr/write/read strobes) and the UART TX/RX engines, all in one clock domain, so it needs no CDC.

---
 rtl/uart_regs_fifo_if.sv | 29 ++
 rtl/uart_regs_fifo.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_regs_fifo.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_regs_fifo_if.sv
// Register bus between the APB slave decode and uart_regs_fifo.
// The master drives one-cycle read/write strobes with a byte address; the
// slave answers reads with registered data one cycle after the strobe.
interface uart_regs_fifo_if #(
   parameter int AW = 8,
   parameter int DW = 32
);
   logic [AW-1:0] addr_i;
   logic          write_en_i;
   logic [DW-1:0] write_data_i;
   logic          read_en_i;
   logic [DW-1:0] read_data_o;

   modport master (
      output addr_i,
      output write_en_i,
      output write_data_i,
      output read_en_i,
      input  read_data_o
   );

   modport slave (
      input  addr_i,
      input  write_en_i,
      input  write_data_i,
      input  read_en_i,
      output read_data_o
   );
endinterface

// File: rtl/uart_regs_fifo.sv
// UART register block with TX/RX FIFOs, baud divisor, sticky error flags,
// FIFO level reporting and a registered level interrupt.
// Optional feature: define UART_REGS_LOOPBACK_EN to make CTRL[7] a loopback
// enable that routes every TX FIFO pop straight into the RX FIFO.
//
// TX handshake: tx_valid_o is derived only from registered state and never
// looks at tx_ready_i; a byte leaves the TX FIFO on every clk_i edge where
// tx_valid_o && tx_ready_i. tx_ready_i may depend on tx_valid_o. The engine
// must tolerate tx_valid_o dropping without a transfer (flush or reset).
module uart_regs_fifo #(
   parameter int DW       = 32,
   parameter int AW       = 8,
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8,
   parameter int DIV_W    = 16,
   parameter int DIV_RST  = 868
) (
   input  logic             clk_i,
   input  logic             reset_i,
   uart_regs_fifo_if.slave  bus,
   output logic             tx_enable_o,
   output logic             rx_enable_o,
   output logic [DIV_W-1:0] baud_div_o,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   input  logic             tx_busy_i,
   input  logic [7:0]       rx_data_i,
   input  logic             rx_valid_i,
   input  logic             rx_frame_err_i,
   output logic             irq_o
);

   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_PW + 1;
   localparam int RX_PW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_PW + 1;

   localparam logic [AW-1:0] A_CTRL   = AW'(8'h00);
   localparam logic [AW-1:0] A_STATUS = AW'(8'h04);
   localparam logic [AW-1:0] A_TXD    = AW'(8'h08);
   localparam logic [AW-1:0] A_RXD    = AW'(8'h0C);
   localparam logic [AW-1:0] A_BAUD   = AW'(8'h10);
   localparam logic [AW-1:0] A_LEVEL  = AW'(8'h14);

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic wr_ctrl, wr_status, wr_txd, wr_baud, rd_rxd;
   logic tx_flush, rx_flush;

   assign wr_ctrl   = bus.write_en_i && (bus.addr_i == A_CTRL);
   assign wr_status = bus.write_en_i && (bus.addr_i == A_STATUS);
   assign wr_txd    = bus.write_en_i && (bus.addr_i == A_TXD);
   assign wr_baud   = bus.write_en_i && (bus.addr_i == A_BAUD);
   assign rd_rxd    = bus.read_en_i  && (bus.addr_i == A_RXD);

   // Flush bits are write-one pulses; they never get stored.
   assign tx_flush  = wr_ctrl && bus.write_data_i[5];
   assign rx_flush  = wr_ctrl && bus.write_data_i[6];

   // Only part of the write bus is consumed by the register map.
   logic unused_wdata;
   assign unused_wdata = ^bus.write_data_i;

   // ---------------------------------------------------------------------
   // Control and baud registers
   // ---------------------------------------------------------------------
   logic             tx_en_q, rx_en_q, tx_irq_en_q, rx_irq_en_q, err_irq_en_q;
   logic [DIV_W-1:0] baud_q;
   logic [7:0]       ctrl_rd;

   // CTRL enable bits update on a CTRL write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_en_q      <= 1'b0;
         rx_en_q      <= 1'b0;
         tx_irq_en_q  <= 1'b0;
         rx_irq_en_q  <= 1'b0;
         err_irq_en_q <= 1'b0;
      end else if (wr_ctrl) begin
         tx_en_q      <= bus.write_data_i[0];
         rx_en_q      <= bus.write_data_i[1];
         tx_irq_en_q  <= bus.write_data_i[2];
         rx_irq_en_q  <= bus.write_data_i[3];
         err_irq_en_q <= bus.write_data_i[4];
      end
   end

   // Baud divisor register.
   always_ff @(posedge clk_i) begin
      if (reset_i) baud_q <= DIV_W'(DIV_RST);
      else if (wr_baud) baud_q <= bus.write_data_i[DIV_W-1:0];
   end

   assign tx_enable_o = tx_en_q;
   assign rx_enable_o = rx_en_q;
   assign baud_div_o  = baud_q;

   // ---------------------------------------------------------------------
   // FIFO state
   // ---------------------------------------------------------------------
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_CW-1:0] tx_count;
   logic             tx_full, tx_empty, tx_push, tx_pop, tx_pop_req;
   logic [7:0]       tx_head;

   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_CW-1:0] rx_count;
   logic             rx_full, rx_empty, rx_push, rx_pop, rx_push_req;
   logic [7:0]       rx_head, rx_push_data;
   logic             frame_set;

   assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
   assign rx_empty = (rx_count == '0);
   assign tx_head  = tx_mem[tx_rd_ptr];
   assign rx_head  = rx_mem[rx_rd_ptr];

   // Show-ahead head of the TX FIFO; held at zero while the FIFO is empty.
   assign tx_data_o = tx_empty ? 8'h00 : tx_head;

`ifdef UART_REGS_LOOPBACK_EN
   logic loopback_q;

   // Loopback enable lives in CTRL[7].
   always_ff @(posedge clk_i) begin
      if (reset_i) loopback_q <= 1'b0;
      else if (wr_ctrl) loopback_q <= bus.write_data_i[7];
   end

   // In loopback the engine is bypassed: pop whenever data is available.
   assign tx_valid_o   = tx_en_q & ~tx_empty & ~loopback_q;
   assign tx_pop_req   = loopback_q ? (tx_en_q & ~tx_empty) : (tx_valid_o & tx_ready_i);
   assign rx_push_req  = rx_en_q & (loopback_q ? tx_pop : rx_valid_i);
   assign rx_push_data = loopback_q ? tx_head : rx_data_i;
   assign frame_set    = ~loopback_q & rx_en_q & rx_valid_i & rx_frame_err_i;
   assign ctrl_rd      = {loopback_q, 2'b00, err_irq_en_q, rx_irq_en_q,
                          tx_irq_en_q, rx_en_q, tx_en_q};
`else
   assign tx_valid_o   = tx_en_q & ~tx_empty;
   assign tx_pop_req   = tx_valid_o & tx_ready_i;
   assign rx_push_req  = rx_en_q & rx_valid_i;
   assign rx_push_data = rx_data_i;
   assign frame_set    = rx_en_q & rx_valid_i & rx_frame_err_i;
   assign ctrl_rd      = {3'b000, err_irq_en_q, rx_irq_en_q,
                          tx_irq_en_q, rx_en_q, tx_en_q};
`endif

   // Flush wins over push/pop; a same-cycle pop frees a slot in a full FIFO.
   assign tx_pop  = tx_pop_req & ~tx_flush;
   assign tx_push = wr_txd & ~tx_flush & (~tx_full | tx_pop);
   assign rx_pop  = rd_rxd & ~rx_empty & ~rx_flush;
   assign rx_push = rx_push_req & ~rx_flush & (~rx_full | rx_pop);

   // TX FIFO pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (reset_i || tx_flush) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + TX_CW'(1);
            2'b01:   tx_count <= tx_count - TX_CW'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   // TX FIFO storage; contents are meaningless while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= bus.write_data_i[7:0];
   end

   // RX FIFO pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (reset_i || rx_flush) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + RX_CW'(1);
            2'b01:   rx_count <= rx_count - RX_CW'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

   // RX FIFO storage.
   always_ff @(posedge clk_i) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
   end

   // ---------------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------------
   logic       tx_ovf_q, rx_orun_q, frame_err_q;
   logic       tx_ovf_set, rx_orun_set;
   logic [7:0] status;

   // A push is dropped only when the FIFO stays full through the edge.
   assign tx_ovf_set  = wr_txd & ~tx_flush & tx_full & ~tx_pop;
   assign rx_orun_set = rx_push_req & ~rx_flush & rx_full & ~rx_pop;

   // Stickies: a new event beats a same-cycle write-one-to-clear.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_ovf_q    <= 1'b0;
         rx_orun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_orun_q   <= rx_orun_set | (rx_orun_q   & ~(wr_status & bus.write_data_i[5]));
         frame_err_q <= frame_set   | (frame_err_q & ~(wr_status & bus.write_data_i[6]));
         tx_ovf_q    <= tx_ovf_set  | (tx_ovf_q    & ~(wr_status & bus.write_data_i[7]));
      end
   end

   assign status = {tx_ovf_q, frame_err_q, rx_orun_q, rx_empty, rx_full,
                    tx_empty, tx_full, tx_busy_i};

   // ---------------------------------------------------------------------
   // Read path and interrupt
   // ---------------------------------------------------------------------
   logic [DW-1:0] rd_mux;
   logic          irq_cond;

   // Read mux over pre-edge state, so a same-cycle write is not seen.
   always_comb begin
      rd_mux = '0;
      case (bus.addr_i)
         A_CTRL:   rd_mux[7:0] = ctrl_rd;
         A_STATUS: rd_mux[7:0] = status;
         A_RXD: begin
            rd_mux[8]   = ~rx_empty;
            rd_mux[7:0] = rx_empty ? 8'h00 : rx_head;
         end
         A_BAUD:   rd_mux[DIV_W-1:0] = baud_q;
         A_LEVEL: begin
            rd_mux[15:0]  = 16'(tx_count);
            rd_mux[31:16] = 16'(rx_count);
         end
         default:  rd_mux = '0;
      endcase
   end

   // Registered read data, held until the next read strobe.
   always_ff @(posedge clk_i) begin
      if (reset_i) bus.read_data_o <= '0;
      else if (bus.read_en_i) bus.read_data_o <= rd_mux;
   end

   assign irq_cond = (tx_irq_en_q & tx_empty) | (rx_irq_en_q & ~rx_empty) |
                     (err_irq_en_q & (|status[7:5]));

   // Interrupt is a registered copy of its condition, one cycle behind.
   always_ff @(posedge clk_i) begin
      if (reset_i) irq_o <= 1'b0;
      else irq_o <= irq_cond;
   end

endmodule

// File: tb/tb_uart_regs_fifo.sv
// Self-checking bench for uart_regs_fifo (default build, loopback disabled).
// A queue-based model tracks the register block and is compared against the
// DUT every cycle; directed steps add literal expectations.
module tb_uart_regs_fifo;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int DIV_W = 16;
  localparam int DIV_RST = 868;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic             tx_enable_o, rx_enable_o, tx_valid_o, irq_o;
  logic [DIV_W-1:0] baud_div_o;
  logic [7:0]       tx_data_o;
  logic             tx_ready_i, tx_busy_i, rx_valid_i, rx_frame_err_i;
  logic [7:0]       rx_data_i;

  uart_regs_fifo_if #(.AW(AW), .DW(DW)) bus ();

  uart_regs_fifo #(
    .DW(DW), .AW(AW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_W(DIV_W), .DIV_RST(DIV_RST)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .bus(bus),
    .tx_enable_o(tx_enable_o),
    .rx_enable_o(rx_enable_o),
    .baud_div_o(baud_div_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .tx_busy_i(tx_busy_i),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_frame_err_i(rx_frame_err_i),
    .irq_o(irq_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]       tx_q[$];
  logic [7:0]       rx_q[$];
  logic [7:0]       tx_log[$];
  int               tx_valid_cycles = 0;
  bit               m_tx_en, m_rx_en, m_txie, m_rxie, m_errie;
  bit               m_ovf, m_orun, m_ferr, m_irq;
  logic [DIV_W-1:0] m_baud;
  logic [31:0]      m_rd;

  function automatic bit m_irq_cond();
    return (m_txie && tx_q.size() == 0) || (m_rxie && rx_q.size() != 0) ||
           (m_errie && (m_ovf || m_orun || m_ferr));
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      8'h00: v = {27'h0, m_errie, m_rxie, m_txie, m_rx_en, m_tx_en};
      8'h04: v = {24'h0, m_ovf, m_ferr, m_orun, rx_q.size() == 0, rx_q.size() == RXD,
                  tx_q.size() == 0, tx_q.size() == TXD, tx_busy_i};
      8'h0C: if (rx_q.size() != 0) v = {23'h0, 1'b1, rx_q[0]};
      8'h10: v = {16'h0, m_baud};
      8'h14: v = {16'(rx_q.size()), 16'(tx_q.size())};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // One clock edge of the register block, from its documented behaviour.
  task automatic model_step();
    bit wr, rd, tx_pop, rx_pop, tx_fl, rx_fl, rx_req, full, irq_next;
    logic [7:0]  a;
    logic [31:0] wd;
    if (reset_i) begin
      tx_q.delete(); rx_q.delete();
      {m_tx_en, m_rx_en, m_txie, m_rxie, m_errie} = '0;
      {m_ovf, m_orun, m_ferr, m_irq} = '0;
      m_baud = DIV_W'(DIV_RST);
      m_rd = 32'h0;
      return;
    end
    wr = bus.write_en_i; rd = bus.read_en_i; a = bus.addr_i; wd = bus.write_data_i;
    irq_next = m_irq_cond();
    if (rd) m_rd = m_read(a);
    tx_fl  = wr && a == 8'h00 && wd[5];
    rx_fl  = wr && a == 8'h00 && wd[6];
    tx_pop = m_tx_en && tx_q.size() != 0 && tx_ready_i;
    rx_pop = rd && a == 8'h0C && rx_q.size() != 0;
    rx_req = rx_valid_i && m_rx_en;
    if (wr && a == 8'h04) begin
      if (wd[5]) m_orun = 0;
      if (wd[6]) m_ferr = 0;
      if (wd[7]) m_ovf = 0;
    end
    if (tx_fl) tx_q.delete();
    else begin
      full = (tx_q.size() == TXD);
      if (tx_pop) tx_q.delete(0);
      if (wr && a == 8'h08) begin
        if (full && !tx_pop) m_ovf = 1;
        else tx_q.push_back(wd[7:0]);
      end
    end
    if (rx_req && rx_frame_err_i) m_ferr = 1;
    if (rx_fl) rx_q.delete();
    else begin
      full = (rx_q.size() == RXD);
      if (rx_pop) rx_q.delete(0);
      if (rx_req) begin
        if (full && !rx_pop) m_orun = 1;
        else rx_q.push_back(rx_data_i);
      end
    end
    if (wr && a == 8'h00) {m_errie, m_rxie, m_txie, m_rx_en, m_tx_en} = wd[4:0];
    if (wr && a == 8'h10) m_baud = wd[DIV_W-1:0];
    m_irq = irq_next;
  endtask

  task automatic compare();
    bit exp_valid;
    exp_valid = m_tx_en && tx_q.size() != 0;
    check("tx_valid", 32'(tx_valid_o), 32'(exp_valid));
    if (tx_q.size() != 0) check("tx_data", 32'(tx_data_o), 32'(tx_q[0]));
    check("read_data", bus.read_data_o, m_rd);
    check("irq", 32'(irq_o), 32'(m_irq));
    check("baud", 32'(baud_div_o), 32'(m_baud));
    check("tx_enable", 32'(tx_enable_o), 32'(m_tx_en));
    check("rx_enable", 32'(rx_enable_o), 32'(m_rx_en));
    if (tx_valid_o) tx_valid_cycles++;
    if (tx_valid_o && tx_ready_i) tx_log.push_back(tx_data_o);
  endtask

  // Compare process: advance the model at the edge, check 1 time unit later.
  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a; bus.write_data_i = d; bus.write_en_i = 1'b1;
    @(negedge clk);
    bus.write_en_i = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a; bus.read_en_i = 1'b1;
    @(negedge clk);
    bus.read_en_i = 1'b0;
    d = bus.read_data_o;
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(negedge clk);
    rx_valid_i = 1'b1; rx_data_i = d;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic expect_read(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  addrs[8];
    logic [31:0] wd;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h08};
    reset_i = 1'b1;
    bus.addr_i = '0; bus.write_en_i = 1'b0; bus.write_data_i = '0; bus.read_en_i = 1'b0;
    tx_ready_i = 1'b0; tx_busy_i = 1'b0; rx_valid_i = 1'b0; rx_frame_err_i = 1'b0; rx_data_i = '0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    // Reset state
    check("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    check("rst_tx_data", 32'(tx_data_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_read_data", bus.read_data_o, 32'h0);
    expect_read("rst_baud", 8'h10, 32'd868);
    expect_read("rst_ctrl", 8'h00, 32'h0);
    expect_read("rst_status", 8'h04, 32'h14);

    // Two TX bytes drained by an always-ready engine
    tx_ready_i = 1'b1;
    bus_write(8'h00, 32'h1);
    tx_log.delete(); tx_valid_cycles = 0;
    bus_write(8'h08, 32'h41);
    bus_write(8'h08, 32'h42);
    repeat (4) @(negedge clk);
    check("tx_log_size", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() == 2) begin
      check("tx_first", 32'(tx_log[0]), 32'h41);
      check("tx_second", 32'(tx_log[1]), 32'h42);
    end
    check("tx_valid_cycles", 32'(tx_valid_cycles), 32'd2);
    tx_ready_i = 1'b0;
    bus_write(8'h00, 32'h0);

    // TX overflow with tx disabled
    for (int i = 0; i < 9; i++) bus_write(8'h08, 32'(8'hA0 + i));
    expect_read("tx_level_full", 8'h14, 32'h8);
    expect_read("tx_ovf_status", 8'h04, 32'h92);
    bus_write(8'h04, 32'h80);
    expect_read("tx_ovf_cleared", 8'h04, 32'h12);
    bus_write(8'h00, 32'h20);
    expect_read("tx_flushed", 8'h14, 32'h0);

    // RX overrun and in-order readout
    bus_write(8'h00, 32'h2);
    for (int i = 0; i < 9; i++) rx_push(8'(8'h10 + i));
    expect_read("rx_orun_status", 8'h04, 32'h2C);
    for (int i = 0; i < 8; i++) expect_read("rx_data", 8'h0C, 32'h100 | 32'(8'h10 + i));
    expect_read("rx_data_empty", 8'h0C, 32'h0);
    bus_write(8'h04, 32'h20);

    // RX-available interrupt timing
    bus_write(8'h00, 32'h0A);
    @(negedge clk); rx_valid_i = 1'b1; rx_data_i = 8'h55;
    @(negedge clk); rx_valid_i = 1'b0;
    check("irq_lag", 32'(irq_o), 32'h0);
    @(negedge clk);
    check("irq_rise", 32'(irq_o), 32'h1);
    expect_read("irq_rx_byte", 8'h0C, 32'h155);
    check("irq_after_pop", 32'(irq_o), 32'h1);
    @(negedge clk);
    check("irq_fall", 32'(irq_o), 32'h0);
    bus_write(8'h00, 32'h02);

    // Push+pop on full RX FIFO, then flush against a push
    for (int i = 0; i < 8; i++) rx_push(8'(8'h60 + i));
    @(negedge clk);
    rx_valid_i = 1'b1; rx_data_i = 8'h68; bus.addr_i = 8'h0C; bus.read_en_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0; bus.read_en_i = 1'b0;
    check("full_pushpop_data", bus.read_data_o, 32'h160);
    expect_read("full_pushpop_level", 8'h14, 32'h0008_0000);
    expect_read("full_pushpop_status", 8'h04, 32'h0C);
    @(negedge clk);
    bus.addr_i = 8'h00; bus.write_data_i = 32'h42; bus.write_en_i = 1'b1;
    rx_valid_i = 1'b1; rx_data_i = 8'h77;
    @(negedge clk);
    bus.write_en_i = 1'b0; rx_valid_i = 1'b0;
    expect_read("flush_level", 8'h14, 32'h0);
    expect_read("flush_status", 8'h04, 32'h14);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset_i = ($urandom_range(0, 599) == 0);
      bus.addr_i = addrs[$urandom_range(0, 7)];
      bus.write_en_i = ($urandom_range(0, 3) == 0);
      bus.read_en_i = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      if (bus.addr_i == 8'h00) begin
        if ($urandom_range(0, 7) != 0) wd[6:5] = 2'b00;
        wd[1:0] = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      end
      bus.write_data_i = wd;
      rx_valid_i = 1'($urandom_range(0, 1));
      rx_data_i = 8'($urandom);
      rx_frame_err_i = ($urandom_range(0, 7) == 0);
      tx_ready_i = 1'($urandom_range(0, 1));
      tx_busy_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset_i = 1'b0; bus.write_en_i = 1'b0; bus.read_en_i = 1'b0;
    rx_valid_i = 1'b0; tx_ready_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
